// File: rtl/axi_mux_aw_w_arbiter.sv
// AW/W arbitration core of an AXI multiplexer: round-robin AW grant with lock-until-ready,
// plus an in-order routing FIFO that steers each W burst from the port whose AW was accepted.
module axi_mux_aw_w_arbiter #(
    parameter int NoSlvPorts = 4,
    parameter int MaxWTrans  = 8,
    parameter int AwWidth    = 64,
    parameter int WWidth     = 80,
    localparam int IdxWidth  = (NoSlvPorts > 1) ? $clog2(NoSlvPorts) : 1,
    localparam int CntWidth  = $clog2(MaxWTrans) + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NoSlvPorts-1:0]         slv_aw_valid_i,
    input  logic [NoSlvPorts*AwWidth-1:0] slv_aw_i,
    output logic [NoSlvPorts-1:0]         slv_aw_ready_o,
    input  logic [NoSlvPorts-1:0]         slv_w_valid_i,
    input  logic [NoSlvPorts*WWidth-1:0]  slv_w_i,
    output logic [NoSlvPorts-1:0]         slv_w_ready_o,
    output logic                          mst_aw_valid_o,
    output logic [AwWidth-1:0]            mst_aw_o,
    input  logic                          mst_aw_ready_i,
    output logic [IdxWidth-1:0]           mst_aw_idx_o,
    output logic                          mst_w_valid_o,
    output logic [WWidth-1:0]             mst_w_o,
    input  logic                          mst_w_ready_i,
    output logic [CntWidth-1:0]           w_fifo_cnt_o,
    output logic                          aw_state_o
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; once valid is
    // raised, it and its payload stay stable until that transfer.
    localparam int PtrWidth = (MaxWTrans > 1) ? $clog2(MaxWTrans) : 1;

    typedef enum logic {AW_IDLE = 1'b0, AW_LOCKED = 1'b1} aw_state_e;

    aw_state_e             state_q, state_d;
    logic [IdxWidth-1:0]   last_q, last_d;
    logic [IdxWidth-1:0]   lock_q, lock_d;
    logic [IdxWidth-1:0]   rr_idx, cand_idx, aw_sel, w_head;
    logic                  rr_found, aw_push, w_pop, fifo_full, fifo_empty;
    logic [AwWidth-1:0]    aw_pl [NoSlvPorts];
    logic [WWidth-1:0]     w_pl  [NoSlvPorts];
    logic [IdxWidth-1:0]   fifo_mem_q [MaxWTrans];
    logic [PtrWidth-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]   cnt_q;

    always_comb begin
        for (int p = 0; p < NoSlvPorts; p++) begin
            aw_pl[p] = slv_aw_i[p*AwWidth +: AwWidth];
            w_pl[p]  = slv_w_i[p*WWidth +: WWidth];
        end
    end

    // Search starts one past the last granted port and wraps.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand_idx = '0;
        for (int i = 1; i <= NoSlvPorts; i++) begin
            cand_idx = IdxWidth'((int'(last_q) + i) % NoSlvPorts);
            if (!rr_found && slv_aw_valid_i[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    assign fifo_full  = (cnt_q == CntWidth'(MaxWTrans));
    assign fifo_empty = (cnt_q == '0);

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        lock_d         = lock_q;
        aw_sel         = lock_q;
        aw_push        = 1'b0;
        mst_aw_valid_o = 1'b0;
        mst_aw_o       = '0;
        mst_aw_idx_o   = '0;
        slv_aw_ready_o = '0;
        case (state_q)
            AW_IDLE: begin
                if (rr_found && !fifo_full) begin
                    aw_sel         = rr_idx;
                    mst_aw_valid_o = 1'b1;
                    if (mst_aw_ready_i) begin
                        aw_push = 1'b1;
                        last_d  = rr_idx;
                    end else begin
                        lock_d  = rr_idx;
                        state_d = AW_LOCKED;
                    end
                end
            end
            AW_LOCKED: begin
                aw_sel         = lock_q;
                mst_aw_valid_o = 1'b1;
                if (mst_aw_ready_i) begin
                    aw_push = 1'b1;
                    last_d  = lock_q;
                    state_d = AW_IDLE;
                end
            end
            default: state_d = AW_IDLE;
        endcase
        if (mst_aw_valid_o) begin
            mst_aw_o               = aw_pl[aw_sel];
            mst_aw_idx_o           = aw_sel;
            slv_aw_ready_o[aw_sel] = mst_aw_ready_i;
        end
        // Outputs read quiet for the whole time reset is held, not just after the edge.
        if (rst_i) begin
            mst_aw_valid_o = 1'b0;
            mst_aw_o       = '0;
            mst_aw_idx_o   = '0;
            slv_aw_ready_o = '0;
            aw_push        = 1'b0;
        end
    end

    always_comb begin
        w_head        = fifo_mem_q[rd_ptr_q];
        mst_w_valid_o = 1'b0;
        mst_w_o       = '0;
        slv_w_ready_o = '0;
        if (!fifo_empty && !rst_i) begin
            mst_w_valid_o         = slv_w_valid_i[w_head];
            mst_w_o               = w_pl[w_head];
            slv_w_ready_o[w_head] = mst_w_ready_i;
        end
        w_pop = mst_w_valid_o && mst_w_ready_i && mst_w_o[0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= AW_IDLE;
            last_q  <= IdxWidth'(NoSlvPorts - 1);
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            lock_q  <= lock_d;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (aw_push) begin
                wr_ptr_q <= (wr_ptr_q == PtrWidth'(MaxWTrans - 1)) ? '0 : wr_ptr_q + PtrWidth'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= (rd_ptr_q == PtrWidth'(MaxWTrans - 1)) ? '0 : rd_ptr_q + PtrWidth'(1);
            end
            if (aw_push && !w_pop) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end else if (w_pop && !aw_push) begin
                cnt_q <= cnt_q - CntWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (aw_push) begin
            fifo_mem_q[wr_ptr_q] <= aw_sel;
        end
    end

    assign w_fifo_cnt_o = cnt_q;
    assign aw_state_o   = state_q;
endmodule

// File: tb/tb_axi_mux_aw_w_arbiter.sv
// Bench for axi_mux_aw_w_arbiter: per-port AW/W bursts with random pacing, a queue-based
// arbitration/routing model, and a W-beat scoreboard fed at each accepted AW.
module tb_axi_mux_aw_w_arbiter;
    localparam int N    = 4;
    localparam int MAXW = 8;
    localparam int AWW  = 64;
    localparam int WW   = 80;
    localparam int NB   = 48;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]     aw_v, w_v;
    logic [AWW-1:0]   aw_d [N];
    logic [WW-1:0]    w_d [N];
    logic [N*AWW-1:0] aw_flat;
    logic [N*WW-1:0]  w_flat;
    logic             mst_aw_ready, mst_w_ready;
    logic [N-1:0]     slv_aw_ready_o, slv_w_ready_o;
    logic             mst_aw_valid_o, mst_w_valid_o, aw_state_o;
    logic [AWW-1:0]   mst_aw_o;
    logic [WW-1:0]    mst_w_o;
    logic [1:0]       mst_aw_idx_o;
    logic [3:0]       w_fifo_cnt_o;

    int checks = 0;
    int failures = 0;

    int len_tab [N][NB];
    logic [31:0] salt_tab [N][NB];
    int aw_k [N];
    int w_k [N];
    int w_bt [N];
    int aw_quota [N];
    logic [N-1:0] w_mask;
    int aw_pct, w_pct, aw_rdy_pct, w_rdy_pct;

    int route_q [$];
    logic [WW-1:0] exp_q [$];
    int gnt_log [$];
    int wpop_log [$];
    int last_gnt = N - 1;
    int lock_idx = -1;
    int aw_hs_cnt = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int p = 0; p < N; p++) begin
            aw_flat[p*AWW +: AWW] = aw_d[p];
            w_flat[p*WW +: WW]    = w_d[p];
        end
    end

    axi_mux_aw_w_arbiter #(.NoSlvPorts(N), .MaxWTrans(MAXW), .AwWidth(AWW), .WWidth(WW)) dut (
        .clk_i(clk), .rst_i(rst),
        .slv_aw_valid_i(aw_v), .slv_aw_i(aw_flat), .slv_aw_ready_o(slv_aw_ready_o),
        .slv_w_valid_i(w_v), .slv_w_i(w_flat), .slv_w_ready_o(slv_w_ready_o),
        .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_o(mst_aw_o), .mst_aw_ready_i(mst_aw_ready),
        .mst_aw_idx_o(mst_aw_idx_o),
        .mst_w_valid_o(mst_w_valid_o), .mst_w_o(mst_w_o), .mst_w_ready_i(mst_w_ready),
        .w_fifo_cnt_o(w_fifo_cnt_o), .aw_state_o(aw_state_o)
    );

    function automatic logic [AWW-1:0] aw_pay(input int p, input int k);
        return {8'(p), 8'(k), 8'(len_tab[p][k]), salt_tab[p][k], 8'hA5};
    endfunction

    function automatic logic [WW-1:0] w_pay(input int p, input int k, input int b);
        return {8'(p), 8'(k), 8'(b), salt_tab[p][k], 23'd0, (b == len_tab[p][k] - 1)};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_gnt(input string name, input int n);
        for (int i = 0; i < 300 && gnt_log.size() < n; i++) tick();
        chk(name, gnt_log.size() >= n, 1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < budget && !idle; i++) begin
            tick();
            idle = (route_q.size() == 0) && (exp_q.size() == 0) && (aw_v == '0) && (w_v == '0) &&
                   (aw_quota[0] + aw_quota[1] + aw_quota[2] + aw_quota[3] == 0);
        end
        chk(name, idle, 1);
    endtask

    // Driver: handshakes seen at the falling edge, new stimulus applied just after the rising edge.
    initial begin
        logic [N-1:0] aw_fire, w_fire;
        aw_v = '0;
        w_v = '0;
        mst_aw_ready = 1'b0;
        mst_w_ready = 1'b0;
        for (int p = 0; p < N; p++) begin
            aw_d[p] = '0;
            w_d[p] = '0;
            aw_k[p] = 0;
            w_k[p] = 0;
            w_bt[p] = 0;
        end
        forever begin
            @(negedge clk);
            aw_fire = aw_v & slv_aw_ready_o;
            w_fire = w_v & slv_w_ready_o;
            @(posedge clk);
            #1;
            if (rst) begin
                for (int p = 0; p < N; p++) begin
                    if (aw_v[p]) aw_k[p]++;
                    w_k[p] = aw_k[p];
                    w_bt[p] = 0;
                end
                aw_v = '0;
                w_v = '0;
                mst_aw_ready = 1'b0;
                mst_w_ready = 1'b0;
                continue;
            end
            for (int p = 0; p < N; p++) begin
                if (aw_fire[p]) begin
                    aw_v[p] = 1'b0;
                    aw_k[p]++;
                end
                if (!aw_v[p] && aw_quota[p] > 0 && aw_k[p] < NB && $urandom_range(1, 100) <= aw_pct) begin
                    aw_v[p] = 1'b1;
                    aw_d[p] = aw_pay(p, aw_k[p]);
                    aw_quota[p]--;
                end
                if (w_fire[p]) begin
                    w_v[p] = 1'b0;
                    w_bt[p]++;
                    if (w_bt[p] == len_tab[p][w_k[p]]) begin
                        w_bt[p] = 0;
                        w_k[p]++;
                    end
                end
                if (!w_v[p] && w_mask[p] && w_k[p] < aw_k[p] + (aw_v[p] ? 1 : 0) &&
                    $urandom_range(1, 100) <= w_pct) begin
                    w_v[p] = 1'b1;
                    w_d[p] = w_pay(p, w_k[p], w_bt[p]);
                end
            end
            mst_aw_ready = ($urandom_range(1, 100) <= aw_rdy_pct);
            mst_w_ready = ($urandom_range(1, 100) <= w_rdy_pct);
        end
    end

    // Monitor: reference arbitration/routing model plus W scoreboard.
    initial begin
        bit ev;
        int ev_idx, h;
        logic [N-1:0] exp_rdy;
        logic [WW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_outputs", {mst_aw_valid_o, slv_aw_ready_o, mst_w_valid_o, slv_w_ready_o,
                                    mst_aw_idx_o, w_fifo_cnt_o, aw_state_o, mst_aw_o, mst_w_o}, '0);
                route_q.delete();
                exp_q.delete();
                last_gnt = N - 1;
                lock_idx = -1;
                continue;
            end
            ev = 1'b0;
            ev_idx = 0;
            if (lock_idx >= 0) begin
                ev = 1'b1;
                ev_idx = lock_idx;
            end else if (aw_v != '0 && route_q.size() < MAXW) begin
                for (int i = 1; i <= N; i++) begin
                    h = (last_gnt + i) % N;
                    if (aw_v[h]) begin
                        ev = 1'b1;
                        ev_idx = h;
                        break;
                    end
                end
            end
            chk("aw_valid", mst_aw_valid_o, ev);
            if (ev) begin
                exp_rdy = '0;
                if (mst_aw_ready) exp_rdy[ev_idx] = 1'b1;
                chk("aw_idx", mst_aw_idx_o, ev_idx);
                chk("aw_data", mst_aw_o, aw_d[ev_idx]);
                chk("aw_ready_vec", slv_aw_ready_o, exp_rdy);
            end else begin
                chk("aw_idle", {mst_aw_o, slv_aw_ready_o, mst_aw_idx_o}, '0);
            end
            if (route_q.size() > 0) begin
                h = route_q[0];
                exp_rdy = '0;
                if (mst_w_ready) exp_rdy[h] = 1'b1;
                chk("w_valid", mst_w_valid_o, w_v[h]);
                chk("w_ready_vec", slv_w_ready_o, exp_rdy);
            end else begin
                chk("w_idle", {mst_w_valid_o, slv_w_ready_o, mst_w_o}, '0);
            end
            chk("fifo_cnt", w_fifo_cnt_o, route_q.size());
            if (mst_w_valid_o && mst_w_ready) begin
                if (exp_q.size() == 0) begin
                    chk("w_unexpected_beat", mst_w_o, '0);
                end else begin
                    e = exp_q.pop_front();
                    chk("w_data", mst_w_o, e);
                    if (e[0]) begin
                        if (route_q.size() > 0) void'(route_q.pop_front());
                        for (int i = 0; i < N; i++) if (slv_w_ready_o[i]) wpop_log.push_back(i);
                    end
                end
            end
            if (mst_aw_valid_o && mst_aw_ready) begin
                aw_hs_cnt++;
                gnt_log.push_back(int'(mst_aw_idx_o));
            end
            if (ev && mst_aw_ready) begin
                route_q.push_back(ev_idx);
                last_gnt = ev_idx;
                lock_idx = -1;
                for (int b = 0; b < len_tab[ev_idx][aw_k[ev_idx]]; b++)
                    exp_q.push_back(w_pay(ev_idx, aw_k[ev_idx], b));
            end else if (ev) begin
                lock_idx = ev_idx;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int g, p;
        int ord5 [5] = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) begin
            aw_quota[i] = 0;
            for (int k = 0; k < NB; k++) begin
                len_tab[i][k] = $urandom_range(1, 4);
                salt_tab[i][k] = $urandom;
            end
        end
        w_mask = '0;
        aw_pct = 100;
        w_pct = 100;
        aw_rdy_pct = 100;
        w_rdy_pct = 100;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // All ports request together with ready held high.
        aw_quota = '{2, 1, 1, 1};
        wait_gnt("rr_grants_seen", 5);
        for (int i = 0; i < 5; i++) if (gnt_log.size() > i) chk("rr_order", gnt_log[i], ord5[i]);
        w_mask = '1;
        wait_idle("drain_rr", 400);
        chk("w_route_count", wpop_log.size(), 5);
        for (int i = 0; i < 5; i++) if (wpop_log.size() > i) chk("w_route_order", wpop_log[i], ord5[i]);

        // Port 2 locked while ready is low; port 0 joins a cycle later.
        w_mask = '0;
        aw_rdy_pct = 0;
        g = gnt_log.size();
        aw_quota[2] = 1;
        tick();
        aw_quota[0] = 1;
        tick();
        tick();
        chk("lock_state", aw_state_o, 1);
        chk("lock_hold_idx", mst_aw_idx_o, 2);
        aw_rdy_pct = 100;
        wait_gnt("lock_grants_seen", g + 2);
        if (gnt_log.size() >= g + 2) begin
            chk("lock_first", gnt_log[g], 2);
            chk("lock_second", gnt_log[g + 1], 0);
        end
        w_mask = '1;
        wait_idle("drain_lock", 400);

        // Nine AWs with W held off: FIFO fills to eight.
        w_mask = '0;
        g = aw_hs_cnt;
        aw_quota = '{3, 2, 2, 2};
        repeat (30) tick();
        chk("full_hs", aw_hs_cnt - g, 8);
        chk("full_cnt", w_fifo_cnt_o, 8);
        chk("full_stall_valid", mst_aw_valid_o, 0);
        chk("full_stall_ready", slv_aw_ready_o, 0);
        w_mask = '1;
        wait_idle("drain_full", 600);
        chk("full_total_hs", aw_hs_cnt - g, 9);

        // Port 1 burst of four ahead of port 3, port 3 W presented first.
        w_mask = '0;
        len_tab[1][aw_k[1]] = 4;
        g = gnt_log.size();
        aw_quota[1] = 1;
        wait_gnt("order_aw1", g + 1);
        aw_quota[3] = 1;
        wait_gnt("order_aw3", g + 2);
        p = wpop_log.size();
        w_mask = 4'b1000;
        repeat (10) tick();
        chk("w_blocked_valid", mst_w_valid_o, 0);
        chk("w_blocked_ready3", slv_w_ready_o[3], 0);
        chk("w_blocked_pops", wpop_log.size() - p, 0);
        w_mask = 4'b1010;
        wait_idle("drain_order", 400);
        chk("w_order_count", wpop_log.size() - p, 2);
        if (wpop_log.size() >= p + 2) begin
            chk("w_order_first", wpop_log[p], 1);
            chk("w_order_second", wpop_log[p + 1], 3);
        end

        // Random traffic on all ports, enough bursts to wrap the FIFO several times.
        aw_quota = '{8, 8, 8, 8};
        aw_pct = 60;
        w_pct = 70;
        aw_rdy_pct = 70;
        w_rdy_pct = 60;
        w_mask = '1;
        wait_idle("drain_random", 4000);

        // Reset while locked and with bursts in flight.
        aw_quota = '{4, 4, 4, 4};
        aw_rdy_pct = 100;
        repeat (6) tick();
        aw_rdy_pct = 0;
        for (int i = 0; i < 100 && aw_state_o != 1'b1; i++) tick();
        chk("pre_rst_locked", aw_state_o, 1);
        rst = 1'b1;
        aw_quota = '{0, 0, 0, 0};
        #1;
        chk("rst_async", {mst_aw_valid_o, slv_aw_ready_o, mst_w_valid_o, slv_w_ready_o,
                          mst_aw_idx_o, w_fifo_cnt_o, aw_state_o}, '0);
        tick();
        tick();
        rst = 1'b0;
        g = gnt_log.size();
        aw_pct = 100;
        aw_rdy_pct = 100;
        aw_quota = '{1, 1, 1, 1};
        wait_gnt("post_rst_grant_seen", g + 1);
        if (gnt_log.size() > g) chk("post_rst_grant", gnt_log[g], 0);
        wait_idle("drain_final", 600);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
